// File: rtl/tensor_core_self_test_if.sv
// ---------------------------------------------------------------------------
// tensor_core_self_test_if
// Bundles the self-test controller's load, issue, result and status signals.
//   slave  : the controller (tensor_core_self_test)
//   master : whatever drives loads/start/clear and models the tensor core
// Load     : load_valid/load_is_expect/load_data -> load_ready
// Control  : clear_in, start_in
// Issue    : instr_valid/instr_data -> instr_ready
// Results  : result_valid/result_data (signed)
// Status   : busy, done, pass_count, fail_count, first_fail_idx,
//            timeout_flag, overrun_flag
// ---------------------------------------------------------------------------
interface tensor_core_self_test_if #(
    parameter int INSTR_WIDTH = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int EXP_DEPTH   = 64
);
    localparam int CNT_W = $clog2(EXP_DEPTH + 1) + 1;
    localparam int IDX_W = $clog2(EXP_DEPTH);

    logic                   load_valid;
    logic                   load_is_expect;
    logic [INSTR_WIDTH-1:0] load_data;
    logic                   load_ready;
    logic                   clear_in;
    logic                   start_in;
    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr_data;
    logic                   instr_ready;
    logic                   result_valid;
    logic [DATA_WIDTH-1:0]  result_data;
    logic                   busy;
    logic                   done;
    logic [CNT_W-1:0]       pass_count;
    logic [CNT_W-1:0]       fail_count;
    logic [IDX_W-1:0]       first_fail_idx;
    logic                   timeout_flag;
    logic                   overrun_flag;

    modport slave (
        input  load_valid, load_is_expect, load_data, clear_in, start_in,
               instr_ready, result_valid, result_data,
        output load_ready, instr_valid, instr_data, busy, done, pass_count,
               fail_count, first_fail_idx, timeout_flag, overrun_flag
    );

    modport master (
        output load_valid, load_is_expect, load_data, clear_in, start_in,
               instr_ready, result_valid, result_data,
        input  load_ready, instr_valid, instr_data, busy, done, pass_count,
               fail_count, first_fail_idx, timeout_flag, overrun_flag
    );
endinterface

// File: rtl/tensor_core_self_test.sv
// ---------------------------------------------------------------------------
// tensor_core_self_test
// Replays a loaded instruction program into a tensor core and scores the
// core's results against a loaded table of expected values.
//   clock_in : sole clock
//   reset_in : asynchronous, active-high reset
//   bus      : tensor_core_self_test_if.slave (load, issue, result, status)
// Flow: IDLE -> RUN (issue program) -> DRAIN (wait for results) -> DONE.
// Memories are only writable in IDLE/DONE; their valid extent is given by
// prog_len / exp_len, so reset and clear only touch the lengths.
// ---------------------------------------------------------------------------
module tensor_core_self_test #(
    parameter int INSTR_WIDTH = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int PROG_DEPTH  = 256,
    parameter int EXP_DEPTH   = 64,
    parameter int TIMEOUT     = 1024
) (
    input  logic                          clock_in,
    input  logic                          reset_in,
    tensor_core_self_test_if.slave        bus
);
    localparam int PA = $clog2(PROG_DEPTH);
    localparam int PW = PA + 1;
    localparam int EA = $clog2(EXP_DEPTH);
    localparam int EW = EA + 1;
    localparam int CW = EW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] prog_len_q, prog_len_d, issue_ptr_q, issue_ptr_d;
    logic [EW-1:0] exp_len_q, exp_len_d, check_ptr_q, check_ptr_d;
    logic [CW-1:0] pass_q, pass_d, fail_q, fail_d;
    logic [EA-1:0] ffi_q, ffi_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          tmo_q, tmo_d, ovr_q, ovr_d;

    logic [INSTR_WIDTH-1:0] prog_mem [PROG_DEPTH];
    logic [DATA_WIDTH-1:0]  exp_mem  [EXP_DEPTH];

    logic ctl_idle, ld_rdy, ld_fire, iv;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CW] ? {CW{1'b1}} : s[CW-1:0];
    endfunction

    always_comb begin
        ctl_idle = (state_q == S_IDLE) || (state_q == S_DONE);
        ld_rdy   = ctl_idle && !bus.start_in &&
                   (bus.load_is_expect ? (exp_len_q < EW'(EXP_DEPTH))
                                       : (prog_len_q < PW'(PROG_DEPTH)));
        ld_fire  = bus.load_valid && ld_rdy;
        iv       = (state_q == S_RUN) && (issue_ptr_q < prog_len_q);
    end

    always_comb begin
        state_d     = state_q;
        prog_len_d  = prog_len_q;
        exp_len_d   = exp_len_q;
        issue_ptr_d = issue_ptr_q;
        check_ptr_d = check_ptr_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        ffi_d       = ffi_q;
        idle_d      = idle_q;
        tmo_d       = tmo_q;
        ovr_d       = ovr_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // clear takes priority over start and load in the same cycle
                if (bus.clear_in) begin
                    state_d     = S_IDLE;
                    prog_len_d  = '0;
                    exp_len_d   = '0;
                    issue_ptr_d = '0;
                    check_ptr_d = '0;
                    pass_d      = '0;
                    fail_d      = '0;
                    ffi_d       = '0;
                    idle_d      = '0;
                    tmo_d       = 1'b0;
                    ovr_d       = 1'b0;
                end else if (bus.start_in) begin
                    state_d     = S_RUN;
                    issue_ptr_d = '0;
                    check_ptr_d = '0;
                    pass_d      = '0;
                    fail_d      = '0;
                    ffi_d       = '0;
                    idle_d      = '0;
                    tmo_d       = 1'b0;
                    ovr_d       = 1'b0;
                end else if (ld_fire) begin
                    if (bus.load_is_expect) exp_len_d  = exp_len_q + 1'b1;
                    else                    prog_len_d = prog_len_q + 1'b1;
                end
            end
            S_RUN: begin
                idle_d = '0;
                // nothing left to offer only happens for an empty program
                if (!iv) begin
                    state_d = S_DRAIN;
                end else if (bus.instr_ready) begin
                    issue_ptr_d = issue_ptr_q + 1'b1;
                    if (issue_ptr_d == prog_len_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (check_ptr_q == exp_len_q) begin
                    state_d = S_DONE;
                end else if (bus.result_valid) begin
                    idle_d = '0;
                end else if (idle_q == TW'(TIMEOUT)) begin
                    // every still-outstanding check is scored as a failure
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                    fail_d  = sat_add(fail_q, CW'(exp_len_q - check_ptr_q));
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_RUN || state_q == S_DRAIN) && bus.result_valid) begin
            if (check_ptr_q < exp_len_q) begin
                check_ptr_d = check_ptr_q + 1'b1;
                if ($signed(bus.result_data) == $signed(exp_mem[check_ptr_q[EA-1:0]])) begin
                    pass_d = sat_add(pass_q, CW'(1));
                end else begin
                    fail_d = sat_add(fail_q, CW'(1));
                    // overruns/timeouts only follow all compares, so a zero
                    // fail count here means this is the first mismatch
                    if (fail_q == '0) ffi_d = check_ptr_q[EA-1:0];
                end
            end else begin
                ovr_d  = 1'b1;
                fail_d = sat_add(fail_q, CW'(1));
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= S_IDLE;
            prog_len_q  <= '0;
            exp_len_q   <= '0;
            issue_ptr_q <= '0;
            check_ptr_q <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            ffi_q       <= '0;
            idle_q      <= '0;
            tmo_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_len_q  <= prog_len_d;
            exp_len_q   <= exp_len_d;
            issue_ptr_q <= issue_ptr_d;
            check_ptr_q <= check_ptr_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            ffi_q       <= ffi_d;
            idle_q      <= idle_d;
            tmo_q       <= tmo_d;
            ovr_q       <= ovr_d;
        end
    end

    // memory contents survive reset; the zeroed lengths invalidate them
    always_ff @(posedge clock_in) begin
        if (ld_fire && !bus.clear_in) begin
            if (bus.load_is_expect) exp_mem[exp_len_q[EA-1:0]]   <= bus.load_data[DATA_WIDTH-1:0];
            else                    prog_mem[prog_len_q[PA-1:0]] <= bus.load_data;
        end
    end

    assign bus.load_ready     = ld_rdy;
    assign bus.instr_valid    = iv;
    assign bus.instr_data     = iv ? prog_mem[issue_ptr_q[PA-1:0]] : '0;
    assign bus.busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done           = (state_q == S_DONE);
    assign bus.pass_count     = pass_q;
    assign bus.fail_count     = fail_q;
    assign bus.first_fail_idx = ffi_q;
    assign bus.timeout_flag   = tmo_q;
    assign bus.overrun_flag   = ovr_q;
endmodule

// File: tb/tb_tensor_core_self_test.sv
// ---------------------------------------------------------------------------
// tb_tensor_core_self_test
// Drives load/start/clear and plays the tensor core (instr_ready, results).
// Expected issue order and end-of-run tallies are pushed into queues when a
// run starts; a negedge monitor pops and compares them as the DUT presents
// instruction handshakes and the rising edge of done.
// ---------------------------------------------------------------------------
module tb_tensor_core_self_test;
    localparam int IW = 16;
    localparam int DW = 8;
    localparam int PD = 256;
    localparam int ED = 64;
    localparam int TO = 16;

    typedef struct {
        int pass_n;
        int fail_n;
        int ffi;
        int tmo;
        int ovr;
    } sum_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_res_cyc = 0;
    int   done_cyc = 0;

    logic [IW-1:0] instr_q[$];
    sum_t          sb_q[$];
    logic [IW-1:0] g_prog[$];
    logic [DW-1:0] g_exp[$];
    logic [DW-1:0] g_res[$];

    logic          done_prev = 1'b0;
    logic          stall_prev = 1'b0;
    logic [IW-1:0] stall_data;
    logic [IW-1:0] exp_i;
    sum_t          s_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tensor_core_self_test_if #(.INSTR_WIDTH(IW), .DATA_WIDTH(DW), .EXP_DEPTH(ED)) bus();

    tensor_core_self_test #(
        .INSTR_WIDTH(IW), .DATA_WIDTH(DW), .PROG_DEPTH(PD), .EXP_DEPTH(ED), .TIMEOUT(TO)
    ) dut (
        .clock_in (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Reference: score results list against expected list by index.
    task automatic push_expect();
        sum_t s;
        int   n;
        int   e;
        bit   found;
        s = '{0, 0, 0, 0, 0};
        n = g_res.size();
        e = g_exp.size();
        found = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= e) begin
                s.fail_n++;
                s.ovr = 1;
            end else if ($signed(g_res[i]) == $signed(g_exp[i])) begin
                s.pass_n++;
            end else begin
                s.fail_n++;
                if (!found) begin
                    s.ffi = i;
                    found = 1;
                end
            end
        end
        if (n < e) begin
            s.tmo = 1;
            s.fail_n += e - n;
        end
        sb_q.push_back(s);
        foreach (g_prog[i]) instr_q.push_back(g_prog[i]);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end else begin
            if (stall_prev && bus.instr_valid) check("stall_hold", bus.instr_data, stall_data);
            if (bus.instr_valid && bus.instr_ready) begin
                if (instr_q.size() == 0) fail_now("extra_instr");
                else begin
                    exp_i = instr_q.pop_front();
                    check("instr_order", bus.instr_data, exp_i);
                end
            end
            stall_prev = bus.instr_valid && !bus.instr_ready;
            stall_data = bus.instr_data;
            if (bus.done && !done_prev) begin
                done_cyc = cyc;
                if (sb_q.size() == 0) fail_now("unexpected_done");
                else begin
                    s_exp = sb_q.pop_front();
                    check("pass_count", bus.pass_count, s_exp.pass_n);
                    check("fail_count", bus.fail_count, s_exp.fail_n);
                    check("first_fail_idx", bus.first_fail_idx, s_exp.ffi);
                    check("timeout_flag", bus.timeout_flag, s_exp.tmo);
                    check("overrun_flag", bus.overrun_flag, s_exp.ovr);
                    check("instr_all_issued", instr_q.size(), 0);
                end
            end
            done_prev = bus.done;
        end
    end

    task automatic pulse_clear();
        @(posedge clk); #1;
        bus.clear_in = 1'b1;
        @(posedge clk); #1;
        bus.clear_in = 1'b0;
    endtask

    task automatic load_beat(input bit is_exp, input logic [IW-1:0] d);
        @(posedge clk); #1;
        bus.load_valid     = 1'b1;
        bus.load_is_expect = is_exp;
        bus.load_data      = d;
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
    endtask

    task automatic load_all();
        logic [7:0] junk;
        pulse_clear();
        foreach (g_prog[i]) load_beat(1'b0, g_prog[i]);
        foreach (g_exp[i]) begin
            junk = 8'($urandom);   // upper payload bits must be ignored
            load_beat(1'b1, {junk, g_exp[i]});
        end
    endtask

    // mode: 0 ready=1, 1 toggle, 2 random, 3 held off 8 cycles (results burst)
    task automatic run_case(input int mode, input int first_gap);
        int gap;
        int rcnt;
        bit fin;
        push_expect();
        @(posedge clk); #1;
        bus.start_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        gap = first_gap;
        rcnt = 0;
        fin = 0;
        for (int k = 0; k < 2000 && !fin; k++) begin
            case (mode)
                0: bus.instr_ready = 1'b1;
                1: bus.instr_ready = k[0];
                2: bus.instr_ready = 1'($urandom_range(0, 1));
                default: bus.instr_ready = (k >= 8);
            endcase
            if (rcnt < g_res.size() && gap == 0) begin
                bus.result_valid = 1'b1;
                bus.result_data  = g_res[rcnt];
                rcnt++;
                last_res_cyc = cyc;
                gap = (mode == 3) ? 0 : int'($urandom_range(0, 3));
            end else begin
                bus.result_valid = 1'b0;
                if (gap > 0) gap--;
            end
            @(posedge clk); #1;
            fin = bus.done;
        end
        bus.result_valid = 1'b0;
        bus.instr_ready  = 1'b0;
        if (!fin) fail_now("run_done_within_budget");
        @(negedge clk); #1;
    endtask

    task automatic set_basic();
        g_prog.delete(); g_exp.delete(); g_res.delete();
        g_prog.push_back(16'h1111); g_prog.push_back(16'h2222); g_prog.push_back(16'h3333);
        g_exp.push_back(8'd5); g_exp.push_back(-8'sd3); g_exp.push_back(8'd7);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] e;
        int            n;
        bus.load_valid = 0; bus.load_is_expect = 0; bus.load_data = '0;
        bus.clear_in = 0; bus.start_in = 0; bus.instr_ready = 0;
        bus.result_valid = 0; bus.result_data = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_instr_valid", bus.instr_valid, 0);
        check("rst_load_ready", bus.load_ready, 1);
        check("rst_pass", bus.pass_count, 0);
        check("rst_fail", bus.fail_count, 0);
        check("rst_timeout", bus.timeout_flag, 0);
        check("rst_overrun", bus.overrun_flag, 0);

        // empty program and table: straight through to DONE, nothing issued
        g_prog.delete(); g_exp.delete(); g_res.delete();
        run_case(0, 0);

        // all match
        set_basic();
        g_res.push_back(8'd5); g_res.push_back(-8'sd3); g_res.push_back(8'd7);
        load_all();
        run_case(0, 0);

        // rerun from DONE with two mismatches
        g_res.delete();
        g_res.push_back(8'd5); g_res.push_back(8'd4); g_res.push_back(-8'sd8);
        run_case(0, 0);

        // clear drops done and tallies
        pulse_clear();
        @(negedge clk);
        check("clr_done", bus.done, 0);
        check("clr_fail", bus.fail_count, 0);
        check("clr_ffi", bus.first_fail_idx, 0);
        check("clr_pass", bus.pass_count, 0);

        // instr_ready toggling
        set_basic();
        g_res.push_back(8'd5); g_res.push_back(-8'sd3); g_res.push_back(8'd7);
        load_all();
        run_case(1, 1);

        // drain timeout: one result for two expected values
        g_prog.delete(); g_exp.delete(); g_res.delete();
        g_prog.push_back(16'hABCD);
        g_exp.push_back(8'd5); g_exp.push_back(-8'sd3);
        g_res.push_back(8'd5);
        load_all();
        run_case(0, 3);
        // result sampled one edge after it is driven, done 17 edges later
        check("timeout_done_latency", done_cyc - last_res_cyc, TO + 2);

        // overrun: four results for three expected values
        set_basic();
        g_res.push_back(8'd5); g_res.push_back(-8'sd3); g_res.push_back(8'd7); g_res.push_back(8'd1);
        load_all();
        run_case(3, 0);

        // randomized programs and result patterns
        for (int t = 0; t < 4; t++) begin
            g_prog.delete(); g_exp.delete(); g_res.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) g_prog.push_back(IW'($urandom));
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                e = DW'($urandom);
                g_exp.push_back(e);
                if ($urandom_range(0, 1) == 1) g_res.push_back(e);
                else g_res.push_back(e ^ DW'($urandom_range(1, 255)));
            end
            load_all();
            run_case(2, $urandom_range(0, 3));
        end

        // reset in the middle of RUN
        g_prog.delete(); g_exp.delete(); g_res.delete();
        for (int i = 0; i < 6; i++) g_prog.push_back(IW'(16'h0100 + i));
        g_exp.push_back(8'd9);
        load_all();
        @(posedge clk); #1 bus.start_in = 1'b1;
        @(posedge clk); #1 bus.start_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_instr_valid", bus.instr_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_instr_valid", bus.instr_valid, 0);
        check("mid_rst_instr_data", bus.instr_data, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        @(posedge clk); #1 rst = 1'b0;
        set_basic();
        g_res.push_back(8'd5); g_res.push_back(-8'sd3); g_res.push_back(8'd7);
        load_all();
        run_case(0, 0);

        // full expected memory blocks further expected beats only
        pulse_clear();
        for (int i = 0; i < ED; i++) load_beat(1'b1, IW'(i));
        @(posedge clk); #1;
        bus.load_is_expect = 1'b1;
        #1 check("full_exp_ready", bus.load_ready, 0);
        bus.load_is_expect = 1'b0;
        #1 check("full_prog_side_ready", bus.load_ready, 1);
        bus.start_in = 1'b1;
        #1 check("start_blocks_ready", bus.load_ready, 0);
        bus.start_in = 1'b0;

        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tensor_core_self_test.md
TENSOR_CORE_SELF_TEST -- requirements
Module: tensor_core_self_test

Interface
REQ-001 SHALL have parameters (name, default, meaning): INSTR_WIDTH, 16, instruction width.
REQ-002 SHALL have parameter DATA_WIDTH, 8, signed result width.
REQ-003 SHALL have parameter PROG_DEPTH, 256, instruction memory entries (power of 2).
REQ-004 SHALL have parameter EXP_DEPTH, 64, expected-result memory entries (power of 2).
REQ-005 SHALL have parameter TIMEOUT, 1024, maximum idle drain cycles.
REQ-006 SHALL have ports (name, direction, width, meaning) as follows.
- clock_in  in  1  sole clock.
- reset_in  in  1  reset; asynchronous, active-high.
- load_valid  in  1  load beat present.
- load_is_expect  in  1  1 = expected value, 0 = instruction.
- load_data  in  INSTR_WIDTH  beat payload; expected value is the low DATA_WIDTH bits.
- load_ready  out  1  load beat accepted when high with load_valid.
- clear_in  in  1  empty both memories.
- start_in  in  1  run pulse.
- instr_valid  out  1  instruction offered to core.
- instr_data  out  INSTR_WIDTH  instruction.
- instr_ready  in  1  core accepts instruction.
- result_valid  in  1  core result strobe.
- result_data  in  DATA_WIDTH  signed core result.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start/clear.
- pass_count, fail_count  out  $clog2(EXP_DEPTH+1)+1  check tallies.
- first_fail_idx  out  $clog2(EXP_DEPTH)  first mismatching check index.
- timeout_flag, overrun_flag  out  1  drain timed out / surplus results.

Function
REQ-007 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE; DONE -> RUN on start_in; DONE -> IDLE on clear_in.
REQ-008 load_ready SHALL be 1 only in IDLE/DONE, with the target memory not full, and start_in low.
REQ-009 Accepted beats SHALL be written at the target write pointer, which then increments; the pointer value gives prog_len / exp_len.
REQ-010 clear_in in IDLE/DONE SHALL zero both lengths, counters, and flags, and set done=0; in RUN/DRAIN it SHALL be ignored.
REQ-011 start_in in IDLE/DONE SHALL zero counters, flags, issue pointer, and check pointer, then enter RUN next cycle; while busy it SHALL be ignored.
REQ-012 In RUN, instr_valid SHALL be 1 and instr_data SHALL equal mem[issue_ptr].
REQ-013 issue_ptr SHALL advance only on instr_valid&instr_ready; a stalled instr_data SHALL be held stable.
REQ-014 After the last instruction handshake, the FSM SHALL enter DRAIN and instr_valid SHALL drop the same edge.
REQ-015 start_in with prog_len=0 SHALL go RUN -> DRAIN without issuing any instruction.
REQ-016 Each result_valid in RUN/DRAIN with check_ptr<exp_len SHALL compare result_data to expected[check_ptr] as a signed full-width compare.
REQ-017 On a match, pass_count SHALL increment; on a mismatch, fail_count SHALL increment and first_fail_idx SHALL be latched on the first mismatch only.
REQ-018 check_ptr SHALL increment on every compared result.
REQ-019 result_valid with check_ptr==exp_len SHALL set overrun_flag and increment fail_count, with no compare.
REQ-020 DRAIN SHALL exit to DONE when check_ptr==exp_len.
REQ-021 DRAIN SHALL exit to DONE when TIMEOUT consecutive cycles pass without result_valid; on that exit timeout_flag=1 and fail_count += exp_len-check_ptr.
REQ-022 A result arriving on the same edge as the last instruction handshake SHALL be counted.
REQ-023 busy SHALL be 1 in RUN/DRAIN; done SHALL be asserted one cycle after the DRAIN exit condition.
REQ-024 Counters SHALL saturate at their maximum value and never wrap.

Reset
REQ-025 reset_in high SHALL asynchronously force IDLE, both lengths, all pointers, counters, first_fail_idx, and flags to 0, with busy=done=instr_valid=0 and load_ready=1 after release.
REQ-026 Reset mid-run SHALL abort with no further instr_valid.
REQ-027 Memory contents need not be cleared by reset; lengths=0 make them invalid.

Verification
REQ-028 Load 3 instr + expected {5,-3,7}, start, instr_ready=1, results {5,-3,7} -> 3 instr beats, pass=3, fail=0, done=1.
REQ-029 Same program, results {5,4,-8} -> pass=1, fail=2, first_fail_idx=1.
REQ-030 instr_ready toggling every other cycle -> instr_data stable while stalled, all 3 issued in order, no duplicates.
REQ-031 exp_len=2, only 1 result, TIMEOUT=16 -> done 17 cycles after the last result, timeout_flag=1, fail=1.
REQ-032 4 results for exp_len=3 -> overrun_flag=1, fail incremented by 1.
REQ-033 reset_in mid-RUN -> instr_valid=0 immediately, all outputs 0; after a reload, the re-run passes cleanly.
